cbus_ram_responder: RTL and testbench
=====================================

Name: cbus_ram_responder

Overview:
Synthesizable CBus responder (slave). It accepts the `cbus_req_t` stream that the top level drives on `oreq`, and returns `cbus_resp_t` as the `oresp` source. It is backed by an internal word-addressed RAM.
It is the memory-side end of the cache/uncached CBus path. It stands in for the AXI bridge in on-chip integration and in cache/arbiter verification, with a programmable initial latency.

Parameters:
MEM_WORDS, 4096, RAM depth in 32-bit words; power of two.
LATENCY, 2, idle cycles between request capture and first data beat; legal range 0..15.

Ports:
clk  input  1  clock; all state updates on the rising edge
resetn  input  1  asynchronous, active-low reset
req  input  cbus_req_t  valid, is_write, size, addr[31:0], strobe[3:0], data[31:0], len (beats = len+1, 1..16)
resp  output  cbus_resp_t  ready, last, data[31:0]
busy  output  1  high whenever the state is not IDLE

Behaviour:
- Reset (resetn=0, asynchronous):
  - State goes to IDLE; resp.ready=0, resp.last=0, resp.data=0, busy=0.
  - Latency and beat counters are cleared.
  - RAM contents are NOT reset.
- States:
  - IDLE -> WAIT when req.valid=1 and LATENCY>0.
  - IDLE -> BURST when req.valid=1 and LATENCY=0.
  - WAIT -> BURST when the latency counter reaches LATENCY-1.
  - BURST -> IDLE on the beat where last=1.
- Capture (IDLE with req.valid=1 at edge T):
  - Latch idx = addr[2 +: log2(MEM_WORDS)], nbeats = len+1, is_write.
  - Set beat counter = 0.
  - addr[1:0] and the upper address bits are ignored for indexing.
- Latency: the first beat (ready=1) occurs in cycle T+1+LATENCY.
- BURST:
  - ready=1 on every cycle for exactly nbeats consecutive cycles; no gaps, no back-pressure.
  - last=1 only on the final beat, coinciding with ready=1.
  - Beat k accesses word (idx+k) mod MEM_WORDS. Wrap at the top of the RAM is silent.
- Read beat:
  - resp.data = RAM[(idx+k) mod MEM_WORDS], full word, during the same cycle that ready=1.
  - req.size and req.strobe are ignored on reads.
- Write beat:
  - At the edge ending the beat, RAM byte i is written with req.data byte i when req.strobe[i]=1.
  - strobe=0000 is a legal no-op beat.
  - resp.data=0 during write beats.
- Master holding rules:
  - The master holds addr, len and is_write stable from capture until last.
  - Data and strobe may change per beat.
  - Mid-burst changes to addr, len or is_write are ignored because those fields are latched.
- req.valid dropping before last (protocol abort):
  - Return to IDLE on the next edge.
  - No write on that cycle; ready and last deasserted from then on.
- After last:
  - The state is IDLE for at least one cycle with ready=0.
  - If req.valid is still high in that IDLE cycle, it is captured as a new request. Masters deassert valid the cycle after last.
- Outside BURST: ready=0, last=0, resp.data=0.
- Reset asserted mid-burst: behaves exactly as the Reset bullet above.
  - A write beat whose edge has not yet occurred is not performed.
  - Completed beats persist.
- busy is high in WAIT and BURST, low in IDLE.

Test Plan:
1. LATENCY=2: single write (addr 0x100, len=0, strobe 1111, data 0xDEADBEEF) at edge T, then single read of 0x100.
   -> write ready/last in cycle T+3; read returns data=0xDEADBEEF with ready=last=1 three cycles after its capture.
2. 16-beat INCR write (addr 0x40, len=15, data 0..15), then 16-beat read of 0x40.
   -> ready for 16 consecutive cycles; last only on beat 16; read data 0,1,...,15 in order.
3. Partial strobe: RAM[0x20]=0x11223344; write strobe=0101, data 0xAABBCCDD.
   -> readback 0x11BB33DD.
4. LATENCY=0 vs LATENCY=15, 4-beat read each.
   -> first ready at T+1 and T+16 respectively; busy high from T+1 through the last beat, low the cycle after.
5. Wrap: MEM_WORDS=4096, 4-beat write at word 4094 (addr 0x3FF8), data A,B,C,D.
   -> RAM[4094]=A, RAM[4095]=B, RAM[0]=C, RAM[1]=D.
6. Reset and abort: resetn pulsed low during beat 3 of an 8-beat write, and separately valid dropped after beat 2.
   -> beats 1-2 (and 1-2 only) written; ready=0 immediately on reset and from the next cycle on abort; next request is served normally.

Source files
------------

// File: rtl/cbus_ram_responder.sv
// CBus responder backed by a word-addressed RAM with a programmable initial latency.
// Serves bursts of 1..16 beats (no back-pressure) and wraps silently at the top of the RAM.
module cbus_ram_responder #(
  parameter int MEM_WORDS = 4096,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic        req_is_write,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_strobe,
  input  logic [31:0] req_data,
  input  logic [3:0]  req_len,
  output logic        resp_ready,
  output logic        resp_last,
  output logic [31:0] resp_data,
  output logic        busy
);
  localparam int AW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

  state_t        state, state_nxt;
  logic [3:0]    lat_cnt, beat_cnt, len_q;
  logic          wr_q;
  logic [AW-1:0] idx_q, word_idx;
  logic [31:0]   mem [MEM_WORDS];
  logic          capture, beat_we, final_beat;
  logic          unused_req;

  // Size and the non-index address bits play no part in a word-wide RAM.
  assign unused_req = ^{req_size, req_addr};

  assign word_idx   = idx_q + AW'(beat_cnt);
  assign final_beat = (beat_cnt == len_q);
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt  = state;
    capture    = 1'b0;
    beat_we    = 1'b0;
    resp_ready = 1'b0;
    resp_last  = 1'b0;
    resp_data  = '0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          capture   = 1'b1;
          state_nxt = (LATENCY == 0) ? BURST : WAIT;
        end
      end
      WAIT: begin
        if (!req_valid) begin
          state_nxt = IDLE;
        end else if (lat_cnt == 4'(LATENCY - 1)) begin
          state_nxt = BURST;
        end
      end
      BURST: begin
        resp_ready = 1'b1;
        resp_last  = final_beat;
        if (!wr_q) begin
          resp_data = mem[word_idx];
        end
        // A dropped valid aborts the burst and suppresses this beat's write.
        beat_we = wr_q && req_valid;
        if (!req_valid || final_beat) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lat_cnt  <= '0;
      beat_cnt <= '0;
      len_q    <= '0;
      wr_q     <= 1'b0;
    end else if (capture) begin
      lat_cnt  <= '0;
      beat_cnt <= '0;
      len_q    <= req_len;
      wr_q     <= req_is_write;
    end else begin
      if (state == WAIT) begin
        lat_cnt <= lat_cnt + 4'd1;
      end
      if (state == BURST) begin
        beat_cnt <= beat_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      idx_q <= req_addr[2 +: AW];
    end
  end

  // RAM contents survive reset; only completed beats ever reach this port.
  always_ff @(posedge clk) begin
    if (beat_we) begin
      for (int i = 0; i < 4; i++) begin
        if (req_strobe[i]) begin
          mem[word_idx][8*i +: 8] <= req_data[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_cbus_ram_responder.sv
// Bench for cbus_ram_responder: three instances (latency 2, 0, 15) driven by directed and
// randomized bursts, checked cycle by cycle against a byte-tracking memory model.
module tb_cbus_ram_responder;
  localparam int NDUT = 3;
  localparam int MW   = 4096;
  localparam int LATS [NDUT] = '{2, 0, 15};

  logic                  clk = 1'b0;
  logic                  resetn;
  logic [NDUT-1:0]       req_valid;
  logic                  req_is_write;
  logic [2:0]            req_size;
  logic [31:0]           req_addr;
  logic [3:0]            req_strobe;
  logic [31:0]           req_data;
  logic [3:0]            req_len;
  logic [NDUT-1:0]       resp_ready, resp_last, busy;
  logic [NDUT-1:0][31:0] resp_data;

  logic [31:0] mdl    [NDUT][MW];
  logic [3:0]  mknown [NDUT][MW];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    cbus_ram_responder #(.MEM_WORDS(MW), .LATENCY(LATS[g])) u_dut (
      .clk         (clk),
      .resetn      (resetn),
      .req_valid   (req_valid[g]),
      .req_is_write(req_is_write),
      .req_size    (req_size),
      .req_addr    (req_addr),
      .req_strobe  (req_strobe),
      .req_data    (req_data),
      .req_len     (req_len),
      .resp_ready  (resp_ready[g]),
      .resp_last   (resp_last[g]),
      .resp_data   (resp_data[g]),
      .busy        (busy[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] bmask(input logic [3:0] kn);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = {8{kn[b]}};
    return r;
  endfunction

  task automatic mdl_write(input int d, input int w, input logic [31:0] data, input logic [3:0] st);
    for (int b = 0; b < 4; b++) begin
      if (st[b]) begin
        mdl[d][w][8*b +: 8] = data[8*b +: 8];
        mknown[d][w][b]     = 1'b1;
      end
    end
  endtask

  // One burst on instance d. stop_at >= 0 ends it at that beat index, either by dropping
  // valid or (by_reset) by pulsing resetn before that beat's closing edge.
  task automatic burst(input int d, input bit wr, input logic [31:0] addr, input int nb,
                       input logic [31:0] wd [16], input logic [3:0] st [16],
                       input int stop_at, input bit by_reset, input bit scramble,
                       output logic [31:0] rd0);
    int lat, idx, w, k;
    logic [31:0] m;
    lat = LATS[d];
    idx = int'(addr[13:2]);
    rd0 = '0;
    @(negedge clk);
    req_addr     = addr;
    req_len      = 4'(nb - 1);
    req_is_write = wr;
    req_size     = 3'($urandom);
    req_data     = wd[0];
    req_strobe   = st[0];
    req_valid[d] = 1'b1;
    for (int c = 1; c <= lat + nb + 1; c++) begin
      k = c - lat - 1;
      @(negedge clk);
      if (k >= 0 && k == stop_at) begin
        if (by_reset) begin
          #2 resetn = 1'b0;
          #1;
          chk($sformatf("d%0d rst ready", d), 32'(resp_ready[d]), 32'd0);
          chk($sformatf("d%0d rst last", d), 32'(resp_last[d]), 32'd0);
          chk($sformatf("d%0d rst busy", d), 32'(busy[d]), 32'd0);
          chk($sformatf("d%0d rst data", d), resp_data[d], 32'd0);
          req_valid[d] = 1'b0;
          @(negedge clk);
          resetn = 1'b1;
        end else begin
          req_valid[d] = 1'b0;
          @(negedge clk);
          chk($sformatf("d%0d abort ready", d), 32'(resp_ready[d]), 32'd0);
          chk($sformatf("d%0d abort last", d), 32'(resp_last[d]), 32'd0);
          chk($sformatf("d%0d abort busy", d), 32'(busy[d]), 32'd0);
        end
        return;
      end
      if (k < 0) begin
        chk($sformatf("d%0d c%0d wait ready", d, c), 32'(resp_ready[d]), 32'd0);
        chk($sformatf("d%0d c%0d wait last", d, c), 32'(resp_last[d]), 32'd0);
        chk($sformatf("d%0d c%0d wait busy", d, c), 32'(busy[d]), 32'd1);
        chk($sformatf("d%0d c%0d wait data", d, c), resp_data[d], 32'd0);
      end else if (k < nb) begin
        w = (idx + k) % MW;
        chk($sformatf("d%0d beat%0d ready", d, k), 32'(resp_ready[d]), 32'd1);
        chk($sformatf("d%0d beat%0d last", d, k), 32'(resp_last[d]), 32'(k == nb - 1));
        chk($sformatf("d%0d beat%0d busy", d, k), 32'(busy[d]), 32'd1);
        if (wr) begin
          chk($sformatf("d%0d beat%0d wdata", d, k), resp_data[d], 32'd0);
          req_data   = wd[k];
          req_strobe = st[k];
          mdl_write(d, w, wd[k], st[k]);
        end else begin
          m = bmask(mknown[d][w]);
          chk($sformatf("d%0d beat%0d rdata w%0d", d, k, w), resp_data[d] & m, mdl[d][w] & m);
          req_strobe = 4'($urandom);
          req_data   = $urandom;
        end
        if (k == 0) rd0 = resp_data[d];
        if (scramble) begin
          req_addr     = $urandom;
          req_len      = 4'($urandom);
          req_is_write = 1'($urandom);
          req_size     = 3'($urandom);
        end
      end else begin
        chk($sformatf("d%0d post ready", d), 32'(resp_ready[d]), 32'd0);
        chk($sformatf("d%0d post last", d), 32'(resp_last[d]), 32'd0);
        chk($sformatf("d%0d post busy", d), 32'(busy[d]), 32'd0);
        chk($sformatf("d%0d post data", d), resp_data[d], 32'd0);
        req_valid[d] = 1'b0;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wd [16];
    logic [3:0]  st [16];
    logic [31:0] rd;
    logic [31:0] addr;
    int nb, d, stop;
    bit wr;

    for (int i = 0; i < NDUT; i++)
      for (int j = 0; j < MW; j++) begin
        mknown[i][j] = 4'h0;
        mdl[i][j]    = '0;
      end
    for (int i = 0; i < 16; i++) begin
      wd[i] = '0;
      st[i] = 4'hF;
    end

    resetn = 1'b0;
    req_valid = '0; req_is_write = 1'b0; req_size = '0; req_addr = '0;
    req_strobe = '0; req_data = '0; req_len = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("d%0d reset ready", i), 32'(resp_ready[i]), 32'd0);
      chk($sformatf("d%0d reset last", i), 32'(resp_last[i]), 32'd0);
      chk($sformatf("d%0d reset busy", i), 32'(busy[i]), 32'd0);
      chk($sformatf("d%0d reset data", i), resp_data[i], 32'd0);
    end
    resetn = 1'b1;

    // single write then read
    wd[0] = 32'hDEADBEEF; st[0] = 4'hF;
    burst(0, 1'b1, 32'h100, 1, wd, st, -1, 1'b0, 1'b0, rd);
    burst(0, 1'b0, 32'h100, 1, wd, st, -1, 1'b0, 1'b0, rd);
    chk("single readback", rd, 32'hDEADBEEF);

    // 16-beat write/read
    for (int i = 0; i < 16; i++) begin wd[i] = 32'(i); st[i] = 4'hF; end
    burst(0, 1'b1, 32'h40, 16, wd, st, -1, 1'b0, 1'b0, rd);
    burst(0, 1'b0, 32'h40, 16, wd, st, -1, 1'b0, 1'b0, rd);

    // partial strobe merge
    wd[0] = 32'h11223344; st[0] = 4'hF;
    burst(0, 1'b1, 32'h20, 1, wd, st, -1, 1'b0, 1'b0, rd);
    wd[0] = 32'hAABBCCDD; st[0] = 4'b0101;
    burst(0, 1'b1, 32'h20, 1, wd, st, -1, 1'b0, 1'b0, rd);
    burst(0, 1'b0, 32'h20, 1, wd, st, -1, 1'b0, 1'b0, rd);
    chk("strobe merge", rd, 32'h11BB33DD);

    // latency 0 and 15 instances
    for (int i = 0; i < 16; i++) begin wd[i] = $urandom; st[i] = 4'hF; end
    for (int i = 1; i < NDUT; i++) begin
      burst(i, 1'b1, 32'h200, 4, wd, st, -1, 1'b0, 1'b0, rd);
      burst(i, 1'b0, 32'h200, 4, wd, st, -1, 1'b0, 1'b0, rd);
      chk($sformatf("d%0d lat first word", i), rd, wd[0]);
    end

    // wrap at the top of the RAM
    wd[0] = 32'hA; wd[1] = 32'hB; wd[2] = 32'hC; wd[3] = 32'hD;
    for (int i = 0; i < 4; i++) st[i] = 4'hF;
    burst(0, 1'b1, 32'h3FF8, 4, wd, st, -1, 1'b0, 1'b0, rd);
    burst(0, 1'b0, 32'h0, 2, wd, st, -1, 1'b0, 1'b0, rd);
    chk("wrap word0", rd, 32'hC);
    burst(0, 1'b0, 32'h3FF8, 4, wd, st, -1, 1'b0, 1'b0, rd);
    chk("wrap word4094", rd, 32'hA);

    // reset during beat 3, then abort after beat 2
    for (int t = 0; t < 2; t++) begin
      addr = (t == 0) ? 32'h400 : 32'h500;
      for (int i = 0; i < 8; i++) begin wd[i] = 32'h5A5A0000 | 32'(i); st[i] = 4'hF; end
      burst(0, 1'b1, addr, 8, wd, st, -1, 1'b0, 1'b0, rd);
      for (int i = 0; i < 8; i++) wd[i] = 32'hC0DE0000 | 32'(i);
      burst(0, 1'b1, addr, 8, wd, st, 2, (t == 0), 1'b0, rd);
      burst(0, 1'b0, addr, 8, wd, st, -1, 1'b0, 1'b0, rd);
      chk($sformatf("cut%0d beat1 written", t), rd, 32'hC0DE0000);
    end

    // randomized traffic in a window straddling the RAM wrap point
    for (int n = 0; n < 90; n++) begin
      d    = $urandom_range(0, NDUT - 1);
      wr   = (n < 20) ? 1'b1 : 1'($urandom);
      nb   = $urandom_range(1, 16);
      addr = $urandom;
      addr[13:2] = 12'((4080 + $urandom_range(0, 31)) % MW);
      for (int i = 0; i < 16; i++) begin wd[i] = $urandom; st[i] = 4'($urandom); end
      stop = ($urandom_range(0, 9) == 0) ? $urandom_range(0, nb - 1) : -1;
      burst(d, wr, addr, nb, wd, st, stop, 1'b0, 1'b1, rd);
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
